alu_op_scheduler: RTL and testbench
===================================

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 63, max cycles in a Start/Wait phase before abort (with CALC_TIMEOUT_EN only).
REQ-002 Clock  in  1  active-high clock, all state on rising edge.
REQ-003 Resetn  in  1  reset, asynchronous, active-low.
REQ-004 OpReq  in  1  requester has a valid operation on Op.
REQ-005 Op  in  2  00 add, 01 sub, 10 multiply, 11 divide.
REQ-006 OpAck  out  1  one-cycle pulse: Op accepted.
REQ-007 AddSub  out  1  to adder/subtractor: 0 add, 1 subtract.
REQ-008 AluLoad  out  1  one-cycle pulse: load adder/subtractor result.
REQ-009 MulStart / DivStart  out  1 each  start request to multiply / divide controller.
REQ-010 MulDone / DivDone  in  1 each  level DONE from multiply / divide controller (high while that engine idles).
REQ-011 ResLoad  out  1  one-cycle pulse: capture multiply/divide result.
REQ-012 Busy  out  1  high in every state except IDLE.
REQ-013 ResValid  out  1  result available; held until ResTaken.
REQ-014 ResTaken  in  1  consumer has taken the result.
REQ-015 Error  out  1  last operation aborted by timeout.

Function
REQ-016 States: IDLE, ALU, MSTART, MWAIT, DSTART, DWAIT, HOLD.
REQ-017 IDLE, OpReq=1: OpAck pulses that cycle, Op latched into OpReg, Error cleared; next state ALU (Op 0x), MSTART (10), DSTART (11).
REQ-018 OpReq while Busy: ignored, no OpAck; requester holds OpReq.
REQ-019 ALU: exactly one cycle; AluLoad=1, AddSub=OpReg[0]; next HOLD. Op-accept to ResValid latency 2 cycles.
REQ-020 AddSub = OpReg[0] in ALU state, 0 in all other states.
REQ-021 MSTART/DSTART: MulStart/DivStart held high until the matching Done reads 0 (engine has left its end state); then MWAIT/DWAIT with Start low.
REQ-022 MWAIT/DWAIT: on matching Done=1, ResLoad pulses one cycle; next HOLD.
REQ-023 Only one Start output high at a time; Done of the engine not in use is ignored.
REQ-024 HOLD: ResValid=1; ResTaken=1 -> IDLE. OpReq in the same cycle as ResTaken is not accepted; earliest OpAck one cycle later.
REQ-025 ResValid deasserts the cycle after ResTaken is sampled; ResTaken outside HOLD ignored.
REQ-026 Done already 1 on entry to MWAIT/DWAIT (engine finished in one cycle): treated as completion, ResLoad pulses.

Reset
REQ-027 Resetn=0: state IDLE, OpReg=00, timeout counter 0, all outputs 0, immediately and independent of Clock.
REQ-028 Reset mid-operation abandons it: Start outputs drop, no ResLoad, no ResValid; engine recovers through its own DONE handshake.
REQ-029 First OpAck possible on the first rising edge after Resetn returns high.

Configuration
REQ-030 Macro CALC_TIMEOUT_EN defined: 8-bit counter clears on entry to MSTART/DSTART, increments each cycle in START/WAIT states; reaching TIMEOUT_CYCLES -> HOLD with Error=1, ResValid=1, Start low, no ResLoad.
REQ-031 Error holds until next OpAck or reset.
REQ-032 Macro undefined: no counter, Error tied 0, WAIT states wait indefinitely.

Verification
REQ-033 Op=01, OpReq pulse from IDLE -> OpAck cycle 0, AluLoad=1 with AddSub=1 cycle 1, ResValid=1 cycle 2 until ResTaken.
REQ-034 Op=11, DivDone falls 1 cycle after DivStart, rises 40 cycles later -> DivStart high exactly 1 cycle... until DivDone=0, ResLoad single pulse on DivDone rise, then ResValid.
REQ-035 Op=10 accepted, second OpReq Op=00 during MWAIT -> no OpAck until after ResTaken; then accepted one cycle after HOLD exit.
REQ-036 Resetn low during DWAIT -> DivStart, Busy, ResValid 0 immediately; state IDLE; no ResLoad.
REQ-037 CALC_TIMEOUT_EN, TIMEOUT_CYCLES=63, Op=11, DivDone stuck 1 -> after 63 cycles Error=1, ResValid=1, DivStart=0; next OpAck clears Error.
REQ-038 Op=10 with MulDone low 1 cycle then high -> one ResLoad pulse, ResValid next cycle.

Source files
------------

// File: rtl/alu_op_scheduler_if.sv
// Handshake bundle between the op requester, the result consumer and the
// add/sub, multiply and divide engines that alu_op_scheduler sequences.
interface alu_op_scheduler_if;
  logic       op_req;
  logic [1:0] op;
  logic       op_ack;
  logic       add_sub;
  logic       alu_load;
  logic       mul_start;
  logic       div_start;
  logic       mul_done;
  logic       div_done;
  logic       res_load;
  logic       busy;
  logic       res_valid;
  logic       res_taken;
  logic       error;

  // Environment side: requester, consumer and engine DONE levels.
  modport master (
    output op_req, op, res_taken, mul_done, div_done,
    input  op_ack, add_sub, alu_load, mul_start, div_start, res_load,
           busy, res_valid, error
  );

  // Scheduler side.
  modport slave (
    input  op_req, op, res_taken, mul_done, div_done,
    output op_ack, add_sub, alu_load, mul_start, div_start, res_load,
           busy, res_valid, error
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Accepts one ALU op at a time and sequences the add/sub, multiply or divide engine.
// Optional macro CALC_TIMEOUT_EN: abort Start/Wait phases after TIMEOUT_CYCLES cycles.
module alu_op_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_scheduler_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for op_req; op_ack given here only
  // ALU    | one cycle, add/sub result loaded
  // MSTART | mul_start high until mul_done drops
  // MWAIT  | waiting for mul_done to rise
  // DSTART | div_start high until div_done drops
  // DWAIT  | waiting for div_done to rise
  // HOLD   | res_valid high until res_taken
  typedef enum logic [2:0] {
    S_IDLE,
    S_ALU,
    S_MSTART,
    S_MWAIT,
    S_DSTART,
    S_DWAIT,
    S_HOLD
  } state_t;

  state_t     state;
  logic [1:0] op_reg;
  logic       alu_load_q;
  logic       mul_start_q;
  logic       div_start_q;
  logic       busy_q;
  logic       res_valid_q;
  logic       eng_done;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("alu_op_scheduler: TIMEOUT_CYCLES must be within 1..256");
  end

  assign eng_done = ((state == S_MWAIT) && bus.mul_done) ||
                    ((state == S_DWAIT) && bus.div_done);

  // Ack is gated by rst_n so a held op_req cannot show through during reset.
  assign bus.op_ack    = rst_n && (state == S_IDLE) && bus.op_req;
  assign bus.res_load  = eng_done;
  assign bus.add_sub   = (state == S_ALU) && !op_reg[1] && op_reg[0];
  assign bus.alu_load  = alu_load_q;
  assign bus.mul_start = mul_start_q;
  assign bus.div_start = div_start_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;

`ifdef CALC_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       error_q;
  logic       in_eng;

  assign in_eng    = state inside {S_MSTART, S_MWAIT, S_DSTART, S_DWAIT};
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_reg      <= 2'b00;
      alu_load_q  <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      tmo_cnt     <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      alu_load_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.op_req) begin
            op_reg <= bus.op;
            busy_q <= 1'b1;
            if (!bus.op[1]) begin
              state      <= S_ALU;
              alu_load_q <= 1'b1;
            end else if (bus.op[0]) begin
              state       <= S_DSTART;
              div_start_q <= 1'b1;
            end else begin
              state       <= S_MSTART;
              mul_start_q <= 1'b1;
            end
          end
        end
        S_ALU: begin
          state       <= S_HOLD;
          res_valid_q <= 1'b1;
        end
        // Start is held until the engine has visibly left its DONE state.
        S_MSTART: begin
          if (!bus.mul_done) begin
            state       <= S_MWAIT;
            mul_start_q <= 1'b0;
          end
        end
        S_MWAIT: begin
          if (bus.mul_done) begin
            state       <= S_HOLD;
            res_valid_q <= 1'b1;
          end
        end
        S_DSTART: begin
          if (!bus.div_done) begin
            state       <= S_DWAIT;
            div_start_q <= 1'b0;
          end
        end
        S_DWAIT: begin
          if (bus.div_done) begin
            state       <= S_HOLD;
            res_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.res_taken) begin
            state       <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          mul_start_q <= 1'b0;
          div_start_q <= 1'b0;
        end
      endcase
`ifdef CALC_TIMEOUT_EN
      // A real completion on the terminal cycle wins over the abort.
      if ((state == S_IDLE) && bus.op_req) begin
        tmo_cnt <= '0;
        error_q <= 1'b0;
      end else if (in_eng && !eng_done) begin
        if (tmo_cnt == TMO_LAST) begin
          state       <= S_HOLD;
          res_valid_q <= 1'b1;
          error_q     <= 1'b1;
          mul_start_q <= 1'b0;
          div_start_q <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: scenario tasks with a result scoreboard.
// Covers the CALC_TIMEOUT_EN build when that macro is defined.
module tb_alu_op_scheduler;

  logic clk = 1'b0;
  logic rst_n;

  alu_op_scheduler_if bus();

  alu_op_scheduler #(.TIMEOUT_CYCLES(63)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  int         n_ack = 0;
  int         n_alu = 0;
  int         n_mul_start = 0;
  int         n_div_start = 0;
  int         n_res_load = 0;
  int         n_both = 0;
  logic [1:0] last_eng = 2'b00;

  // Monitor: which engine was last driven, and pulse counts.
  always @(negedge clk) begin
    if (bus.op_ack === 1'b1) n_ack++;
    if (bus.alu_load === 1'b1) begin
      n_alu++;
      last_eng = {1'b0, bus.add_sub};
    end
    if (bus.mul_start === 1'b1) begin
      n_mul_start++;
      last_eng = 2'b10;
    end
    if (bus.div_start === 1'b1) begin
      n_div_start++;
      last_eng = 2'b11;
    end
    if (bus.res_load === 1'b1) n_res_load++;
    if (bus.mul_start === 1'b1 && bus.div_start === 1'b1) n_both++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold op_req until acknowledged (bounded), push the expected result.
  task automatic issue_op(input logic [1:0] o, input logic e, output bit ok, output int waited);
    exp_t x;
    ok = 1'b0;
    waited = 0;
    bus.op = o;
    bus.op_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.op_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    if (ok) begin
      x.op = o;
      x.err = e;
      exp_q.push_back(x);
    end
    tick();
    bus.op_req = 1'b0;
  endtask

  task automatic take_res;
    tick();
    bus.res_taken = 1'b1;
    tick();
    bus.res_taken = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    bus.op_req = 1'b0;
    bus.op = 2'b00;
    bus.res_taken = 1'b0;
    bus.mul_done = 1'b1;
    bus.div_done = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.op_ack, bus.add_sub, bus.alu_load, bus.mul_start, bus.div_start,
         bus.res_load, bus.busy, bus.res_valid, bus.error} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000000",
               {bus.op_ack, bus.add_sub, bus.alu_load, bus.mul_start, bus.div_start,
                bus.res_load, bus.busy, bus.res_valid, bus.error});
    end
    bus.op_req = 1'b1;
    bus.op = 2'b10;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({bus.op_ack, bus.busy, bus.mul_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ignores_req got %b exp 000", {bus.op_ack, bus.busy, bus.mul_start});
    end
    bus.op_req = 1'b0;
  endtask

  task automatic test_alu(input logic [1:0] o, input bit release_reset);
    bit   ok;
    int   w;
    exp_t x;
    tick();
    bus.op = o;
    bus.op_req = 1'b1;
    if (release_reset) rst_n = 1'b1;
    issue_op(o, 1'b0, ok, w);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL alu_ack got none exp ack for op %0d", o);
    end
    if (release_reset) begin
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL first_ack_after_reset got %0d wait cycles exp 0", w);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.alu_load, bus.add_sub, bus.res_valid, bus.busy} !== {1'b1, o[0], 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL alu_cycle1 got %b exp %b",
               {bus.alu_load, bus.add_sub, bus.res_valid, bus.busy}, {1'b1, o[0], 1'b0, 1'b1});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.alu_load, bus.add_sub} !== 3'b100) begin
      errors++;
      $display("FAIL alu_cycle2 got %b exp 100", {bus.res_valid, bus.alu_load, bus.add_sub});
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL alu_sb got unexpected result exp none pending");
    end else begin
      x = exp_q.pop_front();
      if ({last_eng, bus.error} !== {x.op, x.err}) begin
        errors++;
        $display("FAIL alu_sb got %b exp %b", {last_eng, bus.error}, {x.op, x.err});
      end
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_hold got %b exp 1", bus.res_valid);
    end
    take_res();
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL alu_taken got %b exp 00", {bus.res_valid, bus.busy});
    end
  endtask

  task automatic test_div;
    bit   ok;
    int   w, s_div, s_mul, s_rl;
    exp_t x;
    tick();
    s_div = n_div_start;
    s_mul = n_mul_start;
    s_rl = n_res_load;
    issue_op(2'b11, 1'b0, ok, w);
    bus.div_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({ok, bus.div_start, bus.busy} !== 3'b111) begin
      errors++;
      $display("FAIL div_start got %b exp 111", {ok, bus.div_start, bus.busy});
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 10) bus.mul_done = 1'b0;
      if (i == 15) bus.mul_done = 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.div_start, bus.mul_start} !== 3'b000 || n_res_load != s_rl) begin
      errors++;
      $display("FAIL div_wait got %b rl %0d exp 000 rl %0d",
               {bus.res_valid, bus.div_start, bus.mul_start}, n_res_load, s_rl);
    end
    checks++;
    if (n_div_start - s_div != 1) begin
      errors++;
      $display("FAIL div_start_len got %0d exp 1", n_div_start - s_div);
    end
    tick();
    bus.div_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.res_load, bus.res_valid} !== 2'b10) begin
      errors++;
      $display("FAIL div_resload got %b exp 10", {bus.res_load, bus.res_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_load} !== 2'b10 || n_res_load - s_rl != 1 || n_mul_start != s_mul) begin
      errors++;
      $display("FAIL div_done got %b rl %0d mul %0d exp 10 rl 1 mul 0",
               {bus.res_valid, bus.res_load}, n_res_load - s_rl, n_mul_start - s_mul);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL div_sb got unexpected result exp none pending");
    end else begin
      x = exp_q.pop_front();
      if ({last_eng, bus.error} !== {x.op, x.err}) begin
        errors++;
        $display("FAIL div_sb got %b exp %b", {last_eng, bus.error}, {x.op, x.err});
      end
    end
    take_res();
  endtask

  task automatic test_mul_quick;
    bit   ok;
    int   w, s_mul, s_rl;
    exp_t x;
    tick();
    s_mul = n_mul_start;
    s_rl = n_res_load;
    issue_op(2'b10, 1'b0, ok, w);
    bus.mul_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({ok, bus.mul_start, bus.div_start} !== 3'b110) begin
      errors++;
      $display("FAIL mul_start got %b exp 110", {ok, bus.mul_start, bus.div_start});
    end
    tick();
    bus.mul_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.res_load, bus.mul_start, bus.res_valid} !== 3'b100) begin
      errors++;
      $display("FAIL mul_resload got %b exp 100", {bus.res_load, bus.mul_start, bus.res_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_load} !== 2'b10 || n_res_load - s_rl != 1 || n_mul_start - s_mul != 1) begin
      errors++;
      $display("FAIL mul_done got %b rl %0d st %0d exp 10 rl 1 st 1",
               {bus.res_valid, bus.res_load}, n_res_load - s_rl, n_mul_start - s_mul);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL mul_sb got unexpected result exp none pending");
    end else begin
      x = exp_q.pop_front();
      if ({last_eng, bus.error} !== {x.op, x.err}) begin
        errors++;
        $display("FAIL mul_sb got %b exp %b", {last_eng, bus.error}, {x.op, x.err});
      end
    end
    take_res();
  endtask

  task automatic test_back_to_back;
    bit   ok;
    int   w, s_ack;
    exp_t x;
    tick();
    issue_op(2'b10, 1'b0, ok, w);
    bus.mul_done = 1'b0;
    tick();
    s_ack = n_ack;
    bus.op = 2'b00;
    bus.op_req = 1'b1;
    repeat (5) tick();
    bus.mul_done = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.op_ack} !== 2'b10) begin
      errors++;
      $display("FAIL busy_ignore got %b exp 10", {bus.res_valid, bus.op_ack});
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL b2b_sb1 got unexpected result exp none pending");
    end else begin
      x = exp_q.pop_front();
      if ({last_eng, bus.error} !== {x.op, x.err}) begin
        errors++;
        $display("FAIL b2b_sb1 got %b exp %b", {last_eng, bus.error}, {x.op, x.err});
      end
    end
    tick();
    bus.res_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.op_ack !== 1'b0 || n_ack != s_ack) begin
      errors++;
      $display("FAIL ack_with_taken got %b acks %0d exp 0 acks 0", bus.op_ack, n_ack - s_ack);
    end
    tick();
    bus.res_taken = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.op_ack, bus.res_valid} !== 2'b10) begin
      errors++;
      $display("FAIL ack_after_hold got %b exp 10", {bus.op_ack, bus.res_valid});
    end
    x.op = 2'b00;
    x.err = 1'b0;
    exp_q.push_back(x);
    tick();
    bus.op_req = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL b2b_second got %b exp 1", bus.res_valid);
    end else begin
      x = exp_q.pop_front();
      if ({last_eng, bus.error} !== {x.op, x.err}) begin
        errors++;
        $display("FAIL b2b_second got %b exp %b", {last_eng, bus.error}, {x.op, x.err});
      end
    end
    take_res();
  endtask

  task automatic test_reset_mid;
    bit ok;
    int w, s_rl;
    tick();
    s_rl = n_res_load;
    issue_op(2'b11, 1'b0, ok, w);
    bus.div_done = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.div_start, bus.busy, bus.res_valid, bus.res_load} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid got %b exp 0000",
               {bus.div_start, bus.busy, bus.res_valid, bus.res_load});
    end
    exp_q.delete();
    bus.div_done = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.busy, bus.div_start} !== 3'b000 || n_res_load != s_rl) begin
      errors++;
      $display("FAIL reset_mid_after got %b rl %0d exp 000 rl 0",
               {bus.res_valid, bus.busy, bus.div_start}, n_res_load - s_rl);
    end
  endtask

`ifdef CALC_TIMEOUT_EN
  task automatic test_timeout;
    bit   ok;
    int   w, k, s_rl;
    exp_t x;
    tick();
    bus.div_done = 1'b1;
    s_rl = n_res_load;
    issue_op(2'b11, 1'b1, ok, w);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) break;
      tick();
      k++;
    end
    checks++;
    if (k != 63) begin
      errors++;
      $display("FAIL timeout_len got %0d exp 63", k);
    end
    checks++;
    if ({bus.error, bus.res_valid, bus.div_start} !== 3'b110 || n_res_load != s_rl) begin
      errors++;
      $display("FAIL timeout_abort got %b rl %0d exp 110 rl 0",
               {bus.error, bus.res_valid, bus.div_start}, n_res_load - s_rl);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL timeout_sb got unexpected result exp none pending");
    end else begin
      x = exp_q.pop_front();
      if ({last_eng, bus.error} !== {x.op, x.err}) begin
        errors++;
        $display("FAIL timeout_sb got %b exp %b", {last_eng, bus.error}, {x.op, x.err});
      end
    end
    take_res();
    @(negedge clk);
    checks++;
    if ({bus.error, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL error_hold got %b exp 10", {bus.error, bus.busy});
    end
    tick();
    issue_op(2'b00, 1'b0, ok, w);
    @(negedge clk);
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear got %b exp 0", bus.error);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL timeout_next got %b exp 1", bus.res_valid);
    end else begin
      x = exp_q.pop_front();
      if ({last_eng, bus.error} !== {x.op, x.err}) begin
        errors++;
        $display("FAIL timeout_next got %b exp %b", {last_eng, bus.error}, {x.op, x.err});
      end
    end
    take_res();
  endtask
`else
  task automatic test_no_timeout;
    bit ok;
    int w;
    tick();
    bus.div_done = 1'b1;
    issue_op(2'b11, 1'b0, ok, w);
    repeat (100) tick();
    @(negedge clk);
    checks++;
    if ({bus.div_start, bus.busy, bus.res_valid, bus.error} !== 4'b1100) begin
      errors++;
      $display("FAIL no_timeout got %b exp 1100",
               {bus.div_start, bus.busy, bus.res_valid, bus.error});
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    test_reset();
    test_alu(2'b01, 1'b1);
    test_alu(2'b00, 1'b0);
    test_div();
    test_mul_quick();
    test_back_to_back();
    test_reset_mid();
`ifdef CALC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    checks++;
    if (exp_q.size() != 0 || n_both != 0) begin
      errors++;
      $display("FAIL final got pending %0d both %0d exp 0 0", exp_q.size(), n_both);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
